// File: rtl/pla_exp_stream.sv
// Streaming piecewise-linear exp(x): clamp, segment lookup, multiply, add, saturate to [0, 2^(W-1)-1].
// Latency 3 cycles from acceptance to out_valid; 1 sample per cycle throughput.
// Single global stall (out_valid && !out_ready) freezes all stages; in_ready = !stall. Optional PLA_EXP_STATUS_EN adds out_flags.
module pla_exp_stream #(
  parameter int W        = 32,
  parameter int Q        = 26,
  parameter int H_SHIFT  = 26,
  parameter int NSEG     = 32,
  parameter int XMIN_INT = -16,
  parameter int AW       = $clog2(NSEG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_y,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic signed [W-1:0] cfg_w,
  input  logic signed [W-1:0] cfg_b
`ifdef PLA_EXP_STATUS_EN
  ,
  output logic [1:0]          out_flags
`endif
);

  // Domain bounds carried with two guard bits so XMIN + span cannot wrap.
  localparam logic signed [W+1:0] XMIN_E = (W+2)'(XMIN_INT) <<< Q;
  localparam logic signed [W+1:0] XMAX_E = XMIN_E + ((W+2)'(NSEG) <<< H_SHIFT) - (W+2)'(1);
  localparam logic signed [2*W-1:0] YMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};

  logic stall;

  logic signed [W-1:0] w_tab [NSEG];
  logic signed [W-1:0] b_tab [NSEG];

  logic signed [W+1:0] x_e;
  logic signed [W+1:0] x_c_e;
  logic [W+1:0]        off;
  logic [W+1:0]        idx_full;
  logic [AW-1:0]       idx;
  logic                clamp_c;
  logic                unused_idx_bits;

  logic                v1, v2;
  logic signed [W-1:0] x1, w1, b1, b2;
  logic signed [2*W-1:0] p2;
  logic                c1, c2;

  logic signed [2*W-1:0] s3;
  logic signed [W-1:0]   y_sat;
  logic                  sat3;
  logic                  flag_clamp_q, flag_sat_q;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Clamp the input to the table domain and derive the segment index.
  always_comb begin
    x_e     = {{2{in_x[W-1]}}, in_x};
    x_c_e   = x_e;
    clamp_c = 1'b0;
    if (x_e < XMIN_E) begin
      x_c_e   = XMIN_E;
      clamp_c = 1'b1;
    end else if (x_e > XMAX_E) begin
      x_c_e   = XMAX_E;
      clamp_c = 1'b1;
    end
    off      = x_c_e - XMIN_E;
    idx_full = off >> H_SHIFT;
    idx      = idx_full[AW-1:0];
  end

  // Upper index bits are zero by construction of the clamp.
  assign unused_idx_bits = ^idx_full[W+1:AW];

  // Coefficient tables: written at any time; a same-cycle read sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        w_tab[i] <= '0;
        b_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      w_tab[cfg_addr] <= cfg_w;
      b_tab[cfg_addr] <= cfg_b;
    end
  end

  // Stage 1: capture clamped x and its segment coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      w1 <= '0;
      b1 <= '0;
      c1 <= 1'b0;
    end else if (!stall) begin
      v1 <= in_valid;
      x1 <= x_c_e[W-1:0];
      w1 <= w_tab[idx];
      b1 <= b_tab[idx];
      c1 <= clamp_c;
    end
  end

  // Stage 2: full-width signed product, intercept and flags ride alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      p2 <= '0;
      b2 <= '0;
      c2 <= 1'b0;
    end else if (!stall) begin
      v2 <= v1;
      p2 <= (2*W)'(w1) * (2*W)'(x1);
      b2 <= b1;
      c2 <= c1;
    end
  end

  // Rescale product, add intercept and saturate to the non-negative range.
  always_comb begin
    s3    = (p2 >>> Q) + (2*W)'(b2);
    y_sat = s3[W-1:0];
    sat3  = 1'b0;
    if (s3 < 0) begin
      y_sat = '0;
      sat3  = 1'b1;
    end else if (s3 > YMAX) begin
      y_sat = YMAX[W-1:0];
      sat3  = 1'b1;
    end
  end

  // Stage 3: output register; holds its last value across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_y        <= '0;
      flag_clamp_q <= 1'b0;
      flag_sat_q   <= 1'b0;
    end else if (!stall) begin
      out_valid <= v2;
      if (v2) begin
        out_y        <= y_sat;
        flag_clamp_q <= c2;
        flag_sat_q   <= sat3;
      end
    end
  end

`ifdef PLA_EXP_STATUS_EN
  assign out_flags = {flag_sat_q, flag_clamp_q};
`else
  logic unused_flags;
  assign unused_flags = flag_sat_q ^ flag_clamp_q;
`endif

endmodule

// File: tb/tb_pla_exp_stream.sv
// Directed self-checking bench for pla_exp_stream with default parameters (Q=26, seg16 covers [0,1)).
module tb_pla_exp_stream;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam logic [31:0] ONE  = 32'h0400_0000;
  localparam logic [31:0] HALF = 32'h0200_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_y;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic signed [W-1:0] cfg_w;
  logic signed [W-1:0] cfg_b;
`ifdef PLA_EXP_STATUS_EN
  logic [1:0]          out_flags;
`endif

  pla_exp_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_w    (cfg_w),
    .cfg_b    (cfg_b)
`ifdef PLA_EXP_STATUS_EN
    ,
    .out_flags(out_flags)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [1:0] get_flags();
`ifdef PLA_EXP_STATUS_EN
    return out_flags;
`else
    return 2'b00;
`endif
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input int a, input logic [31:0] w, input logic [31:0] b);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_w = w; cfg_b = b;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Sends one sample into an idle pipe and returns the result and its latency (-1 on timeout).
  task automatic run_one(input logic [31:0] x, output logic [31:0] y, output int lat, output logic [1:0] fl);
    out_ready = 1'b1; in_valid = 1'b1; in_x = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    y  = out_y;
    fl = get_flags();
  endtask

  task automatic test_reset();
    logic [31:0] y; int lat; logic [1:0] fl;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_w = '0; cfg_b = '0;
    #23;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_y !== 32'h0) begin n_fail++; $display("FAIL reset_out_y got %h want 00000000", out_y); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one(HALF, y, lat, fl);
    n_checks++; if (y !== 32'h0 || lat != 3) begin n_fail++; $display("FAIL reset_table_zero got y=%h lat=%0d want y=00000000 lat=3", y, lat); end
  endtask

  task automatic test_basic();
    logic [31:0] y; int lat; logic [1:0] fl;
    cfg_write(16, ONE, ONE);
    run_one(HALF, y, lat, fl);
    n_checks++; if (y !== 32'h0600_0000) begin n_fail++; $display("FAIL basic_y got %h want 06000000", y); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
`ifdef PLA_EXP_STATUS_EN
    n_checks++; if (fl !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b want 00", fl); end
`endif
  endtask

  task automatic test_clamp();
    logic [31:0] y; int lat; logic [1:0] fl;
    cfg_write(0, 32'h0, 32'h1);
    run_one(32'hB000_0000, y, lat, fl);
    n_checks++; if (y !== 32'h0000_0001 || lat != 3) begin n_fail++; $display("FAIL clamp_low got y=%h lat=%0d want y=00000001 lat=3", y, lat); end
`ifdef PLA_EXP_STATUS_EN
    n_checks++; if (fl !== 2'b01) begin n_fail++; $display("FAIL clamp_low_flags got %b want 01", fl); end
`endif
  endtask

  task automatic test_saturate();
    logic [31:0] y; int lat; logic [1:0] fl;
    cfg_write(31, 32'h4000_0000, 32'h0);
    run_one(32'h3E00_0000, y, lat, fl);
    n_checks++; if (y !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_high got %h want 7fffffff", y); end
`ifdef PLA_EXP_STATUS_EN
    n_checks++; if (fl !== 2'b10) begin n_fail++; $display("FAIL sat_high_flags got %b want 10", fl); end
`endif
    run_one(32'h7FFF_FFFF, y, lat, fl);
    n_checks++; if (y !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL clamp_high got %h want 7fffffff", y); end
`ifdef PLA_EXP_STATUS_EN
    n_checks++; if (fl !== 2'b11) begin n_fail++; $display("FAIL clamp_high_flags got %b want 11", fl); end
`endif
    cfg_write(16, 32'hFC00_0000, 32'h0);
    run_one(HALF, y, lat, fl);
    n_checks++; if (y !== 32'h0) begin n_fail++; $display("FAIL sat_neg got %h want 00000000", y); end
`ifdef PLA_EXP_STATUS_EN
    n_checks++; if (fl !== 2'b10) begin n_fail++; $display("FAIL sat_neg_flags got %b want 10", fl); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [8];
    logic [31:0] prev_y;
    logic        prev_stall;
    int sent, got, cyc, low, extra;
    cfg_write(16, ONE, 32'h0);
    for (int k = 0; k < 8; k++) xs[k] = 32'h0010_0000 * (k + 1);
    sent = 0; got = 0; cyc = 0; low = 0; prev_stall = 1'b0; prev_y = '0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 8);
      in_x      = (sent < 8) ? xs[sent] : 32'h0;
      #1;
      if (!in_ready) low++;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++; $display("FAIL stream_in_ready cyc=%0d got %b out_valid=%b out_ready=%b", cyc, in_ready, out_valid, out_ready);
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== prev_y) begin
          n_fail++; $display("FAIL stream_hold cyc=%0d got v=%b y=%h want v=1 y=%h", cyc, out_valid, out_y, prev_y);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_y !== xs[got]) begin n_fail++; $display("FAIL stream_order idx=%0d got %h want %h", got, out_y, xs[got]); end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL stream_count got %0d want 8", got); end
    n_checks++; if (low != 3) begin n_fail++; $display("FAIL stream_stall_cycles got %0d want 3", low); end
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL stream_duplicate got %0d extra outputs want 0", extra); end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] ys [2];
    int got;
    cfg_write(16, ONE, ONE);
    out_ready = 1'b1; in_valid = 1'b1; in_x = HALF;
    cfg_we = 1'b1; cfg_addr = AW'(16); cfg_w = ONE; cfg_b = 32'h0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && got < 2; k++) begin
      if (out_valid) begin ys[got] = out_y; got++; end
      @(posedge clk); #1;
    end
    n_checks++; if (got != 2) begin n_fail++; $display("FAIL wr_count got %0d want 2", got); end
    else begin
      n_checks++; if (ys[0] !== 32'h0600_0000) begin n_fail++; $display("FAIL wr_old_entry got %h want 06000000", ys[0]); end
      n_checks++; if (ys[1] !== 32'h0200_0000) begin n_fail++; $display("FAIL wr_new_entry got %h want 02000000", ys[1]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] y; int lat; logic [1:0] fl; int stale;
    cfg_write(16, ONE, ONE);
    out_ready = 1'b1; in_valid = 1'b1; in_x = HALF;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_inflight got out_valid=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop got out_valid=%b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rst_stale got %0d outputs want 0", stale); end
    run_one(HALF, y, lat, fl);
    n_checks++; if (y !== 32'h0 || lat != 3) begin n_fail++; $display("FAIL rst_table_seg16 got y=%h lat=%0d want y=00000000 lat=3", y, lat); end
    run_one(32'hF400_0000, y, lat, fl);
    n_checks++; if (y !== 32'h0 || lat != 3) begin n_fail++; $display("FAIL rst_table_neg got y=%h lat=%0d want y=00000000 lat=3", y, lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_saturate();
    test_back_to_back();
    test_same_cycle_write();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
